// File: rtl/ifft_prod_scaler_if.sv
// Handshake bundle between the IFFT product scaler and its upstream/downstream.
// The slave modport is the scaler side; the master modport is the environment side.
interface ifft_prod_scaler_if #(
   parameter int OUT_W = 16
);
   // A transfer happens on a rising clock edge where valid and ready are both
   // high; valid never depends on ready, and data is stable while valid is held.
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_sat;

   modport master (
      output in_valid,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_sat
   );

   modport slave (
      input  in_valid,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_sat
   );
endinterface

// File: rtl/ifft_prod_scaler.sv
// Control/consume stage after the IFFT pipelined multiplier: drives ce, tracks tokens,
// round-shifts and saturates products into a credit-managed FIFO. Option: IFFT_MULCE_GATE_EN.
module ifft_prod_scaler #(
   parameter int PROD_W     = 32,
   parameter int OUT_W      = 16,
   parameter int SHIFT      = 15,
   parameter int MUL_LAT    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   ifft_prod_scaler_if.slave bus,
   output logic              mul_ce,
   input  logic [PROD_W-1:0] mul_dout,
   output logic [15:0]       sat_cnt
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [PROD_W:0] RND = (SHIFT > 0) ? ((PROD_W + 1)'(1) << RND_SH) : '0;

   logic               run_q, run_d;
   logic [MUL_LAT-1:0] vsr_q, vsr_d;
   logic [CNT_W-1:0]   credit_q, credit_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]        sat_cnt_q, sat_cnt_d;
   logic [OUT_W:0]     mem_q [FIFO_DEPTH];

   logic               in_ready_w;
   logic               in_fire;
   logic               push;
   logic               pop;
   logic               out_valid_w;
   logic [PROD_W:0]    rnd_sum;
   logic [PROD_W:0]    shifted;
   logic               prod_sat;
   logic [OUT_W-1:0]   prod_scaled;
   logic [OUT_W:0]     mem_wdata;

   // run_q goes high one edge after reset release so ready/ce come only from flops.
   always_comb begin
      run_d       = 1'b1;
      in_ready_w  = run_q & (credit_q != '0);
      in_fire     = bus.in_valid & in_ready_w;
`ifdef IFFT_MULCE_GATE_EN
      mul_ce      = in_fire | (|vsr_q);
`else
      mul_ce      = run_q;
`endif
      push        = mul_ce & vsr_q[MUL_LAT-1];
      out_valid_w = (count_q != '0);
      pop         = out_valid_w & bus.out_ready;

      vsr_d = vsr_q;
      if (mul_ce) begin
         vsr_d    = vsr_q << 1;
         vsr_d[0] = in_fire;
      end

      // Extra top bit keeps the rounding add from wrapping.
      rnd_sum     = {1'b0, mul_dout} + RND;
      shifted     = rnd_sum >> SHIFT;
      prod_sat    = |shifted[PROD_W:OUT_W];
      prod_scaled = prod_sat ? '1 : shifted[OUT_W-1:0];
      mem_wdata   = {prod_sat, prod_scaled};

      credit_d = credit_q - CNT_W'(in_fire) + CNT_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      sat_cnt_d = sat_cnt_q;
      if (push && prod_sat && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q     <= 1'b0;
         vsr_q     <= '0;
         credit_q  <= CNT_W'(FIFO_DEPTH);
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         sat_cnt_q <= '0;
      end else begin
         run_q     <= run_d;
         vsr_q     <= vsr_d;
         credit_q  <= credit_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= mem_wdata;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_data  = out_valid_w ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
   assign bus.out_sat   = out_valid_w ? mem_q[rd_ptr_q][OUT_W] : 1'b0;
   assign sat_cnt       = sat_cnt_q;

endmodule

// File: doc/ifft_prod_scaler.md
Name: ifft_prod_scaler

Overview:
- Control and consume stage placed directly after the IFFT 16x16 unsigned pipelined multiplier.
- Drives the multiplier's ce, and tracks which operand pairs it has accepted using a valid shift register matched to the multiplier's latency.
- Captures each 32-bit product, then round-shifts and saturates it to 16 bits.
- Buffers results in a small FIFO with a valid/ready output. Upstream flow control is credit based, so no product is ever dropped.

Parameters:
- PROD_W, 32, multiplier product width (mul_dout).
- OUT_W, 16, scaled output width.
- SHIFT, 15, right-shift applied to the product (Q15 rescale); 0 means no shift and no rounding.
- MUL_LAT, 3, ce-cycles from operands on the multiplier's din to the product on mul_dout; must equal the instantiated multiplier's register depth.
- FIFO_DEPTH, 8, output buffer entries; power of 2; at least MUL_LAT+2 for 1 result/cycle throughput.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an operand pair on the multiplier din0/din1 this cycle.
- in_ready  out  1  a credit is available; in_fire = in_valid & in_ready.
- mul_ce  out  1  clock enable to the multiplier.
- mul_dout  in  PROD_W  multiplier product.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  OUT_W  scaled result at the FIFO head.
- out_sat  out  1  head entry was saturated.
- sat_cnt  out  16  saturating count of saturated results.

Behaviour:
- **Reset (reset low, asynchronous):**
  - Clears the valid shift register, FIFO pointers, FIFO count and sat_cnt; the credit counter is set to FIFO_DEPTH.
  - Output values during reset: in_ready=0, out_valid=0, out_data=0, out_sat=0, sat_cnt=0, mul_ce=0.
  - Asserting reset mid-operation discards all in-flight and buffered results; nothing stale is emitted after release.
- **Credits:**
  - credit counter = FIFO_DEPTH − FIFO count − tokens in flight.
  - in_ready = (credit != 0) & reset released; it is purely a function of registered state, with no combinational path from out_ready or in_valid.
  - in_fire decrements credit; a pop (out_valid & out_ready) increments it. Both in the same cycle leave it unchanged.
- **Valid shift register vsr[MUL_LAT-1:0]:**
  - On each edge with mul_ce=1: vsr <= {vsr[MUL_LAT-2:0], in_fire}.
  - When mul_ce=0, vsr holds.
- **Push:** when mul_ce=1 and vsr[MUL_LAT-1]=1, mul_dout is sampled, scaled and pushed that edge. Required result: out_valid rises in cycle t+MUL_LAT+1 for a fire in cycle t.
- **Scaling (unsigned):**
  - r = (mul_dout + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed in PROD_W+1 bits so the rounding add cannot overflow.
  - If r > 2^OUT_W−1: store all-ones with sat=1. Otherwise store r[OUT_W-1:0] with sat=0.
  - sat_cnt increments on each saturated push and holds at 0xFFFF.
- **FIFO:**
  - out_valid = (count != 0). out_data/out_sat show the head entry directly.
  - Push and pop in the same cycle leave count unchanged; the pointers wrap modulo FIFO_DEPTH.
  - Push while full cannot occur because of credit accounting. Pop while empty is ignored.
- Order is strictly preserved: results leave in the same order as the in_fire events.

Optional Feature:
- Macro IFFT_MULCE_GATE_EN.
- Defined: mul_ce = in_fire | (|vsr), so the multiplier is clock-gated when idle. The product at the tail is still captured, because ce is high whenever a token is in flight.
- Undefined: mul_ce = 1 whenever reset is released.
- Results and timing at the data ports are identical in both builds.

Test Plan:
- **Single result:** multiplier model, a=0x8000, b=0x8000 (product 0x40000000), fire in cycle t → out_valid in cycle t+4, out_data=0x8000, out_sat=0.
- **Rounding:** a=0x4000, b=0x0003 (product 0xC000) → out_data=0x0002. a=0x0001, b=0x3FFF (product 0x3FFF) → out_data=0x0000.
- **Saturation:** a=0xFFFF, b=0xFFFF (product 0xFFFE0001) → out_data=0xFFFF, out_sat=1, sat_cnt=1. Then 0x10000 saturating pushes → sat_cnt holds at 0xFFFF.
- **Backpressure:** out_ready=0, in_valid=1 held → exactly 8 fires, then in_ready=0. Release out_ready → 8 results in order, then in_ready reasserts.
- **Throughput:** out_ready=1 and 100 back-to-back inputs → in_ready stays 1 throughout and 100 ordered outputs arrive on consecutive cycles.
- **Reset mid-flight:** 3 tokens in flight plus 2 buffered, then pulse reset low → all outputs take their reset values, and after release no output appears without a new fire.
- **Gate build (IFFT_MULCE_GATE_EN):** idle → mul_ce=0. Single fire → mul_ce=1 for exactly MUL_LAT+1 cycles, with the same output as the first scenario.
